// File: rtl/opcodes_pkg.sv
// Instruction word type and mask/match pairs for the control-transfer opcodes.
package opcodes_pkg;

    localparam int unsigned ILEN = 32;

    typedef logic [ILEN-1:0] instruction_t;

    typedef struct packed {
        instruction_t mask;
        instruction_t match;
    } op_match_t;

    localparam op_match_t M_JAL  = '{mask: 32'h0000_007F, match: 32'h0000_006F};
    localparam op_match_t M_JALR = '{mask: 32'h0000_707F, match: 32'h0000_0067};
    localparam op_match_t M_BEQ  = '{mask: 32'h0000_707F, match: 32'h0000_0063};
    localparam op_match_t M_BNE  = '{mask: 32'h0000_707F, match: 32'h0000_1063};
    localparam op_match_t M_BLT  = '{mask: 32'h0000_707F, match: 32'h0000_4063};
    localparam op_match_t M_BGE  = '{mask: 32'h0000_707F, match: 32'h0000_5063};
    localparam op_match_t M_BLTU = '{mask: 32'h0000_707F, match: 32'h0000_6063};
    localparam op_match_t M_BGEU = '{mask: 32'h0000_707F, match: 32'h0000_7063};

    function automatic logic op_is(instruction_t instr, op_match_t m);
        return (instr & m.mask) == m.match;
    endfunction

endpackage

// File: rtl/branch_predict_unit.sv
// Execute-stage branch unit: architectural PC, JAL/JALR/branch resolution,
// 2-bit saturating-counter BHT and saturating branch/mispredict statistics.
module branch_predict_unit
    import opcodes_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BHT_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  instruction_t      instr,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic [XLEN-1:0]   op3,
    input  logic              enable,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   ret_addr,
    output logic              pred_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ret_q, ret_d;
    logic              mis_q, mis_d;
    logic [STAT_W-1:0] bcnt_q, bcnt_d;
    logic [STAT_W-1:0] mcnt_q, mcnt_d;
    logic [1:0]        bht_q [BHT_ENTRIES];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        ctr, ctr_d;
    logic              bht_we;
    logic              is_br, br_taken;
    logic              eq, lt_s, lt_u;
    logic [XLEN-1:0]   pc_inc, jalr_sum;

    assign idx        = pc_q[IDX_W+1:2];
    assign ctr        = bht_q[idx];
    assign pred_taken = ctr[1];

    assign pc_inc   = pc_q + XLEN'(4);
    assign jalr_sum = op1 + op2;
    assign eq       = (op1 == op2);
    assign lt_s     = ($signed(op1) < $signed(op2));
    assign lt_u     = (op1 < op2);

    // Conditional-branch decode and outcome
    always_comb begin
        is_br    = 1'b1;
        br_taken = 1'b0;
        if      (op_is(instr, M_BEQ))  br_taken = eq;
        else if (op_is(instr, M_BNE))  br_taken = ~eq;
        else if (op_is(instr, M_BLT))  br_taken = lt_s;
        else if (op_is(instr, M_BGE))  br_taken = ~lt_s;
        else if (op_is(instr, M_BLTU)) br_taken = lt_u;
        else if (op_is(instr, M_BGEU)) br_taken = ~lt_u;
        else                           is_br    = 1'b0;
    end

    // Next-state: PC, return address, predictor update and statistics
    always_comb begin
        pc_d   = pc_q;
        ret_d  = ret_q;
        mis_d  = 1'b0;
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        bht_we = 1'b0;
        ctr_d  = ctr;
        if (enable) begin
            ret_d = pc_inc;
            pc_d  = pc_inc;
            if (op_is(instr, M_JAL)) begin
                pc_d = op1;
            end else if (op_is(instr, M_JALR)) begin
                pc_d = jalr_sum & ~XLEN'(1);
            end else if (is_br) begin
                if (br_taken) pc_d = pc_q + op3;
                bht_we = 1'b1;
                if (br_taken) ctr_d = (ctr == 2'b11) ? ctr : ctr + 2'd1;
                else          ctr_d = (ctr == 2'b00) ? ctr : ctr - 2'd1;
                mis_d = (pred_taken != br_taken);
                if (!(&bcnt_q))          bcnt_d = bcnt_q + STAT_W'(1);
                if (mis_d && !(&mcnt_q)) mcnt_d = mcnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            ret_q  <= '0;
            mis_q  <= 1'b0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ret_q  <= ret_d;
            mis_q  <= mis_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    // Predictor table resets to weakly not-taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (bht_we) begin
            bht_q[idx] <= ctr_d;
        end
    end

    assign pc_out      = pc_q;
    assign ret_addr    = ret_q;
    assign mispredict  = mis_q;
    assign branch_cnt  = bcnt_q;
    assign mispred_cnt = mcnt_q;

endmodule
